// File: rtl/gen_ce_multi.sv
// gen_ce_multi: shared prescaler base tick feeding NCH loadable clock-enable dividers
module gen_ce_multi #(
    parameter int TCLK  = 20,
    parameter int TBASE = 100000,
    parameter int PSW   = 19,
    parameter int NCH   = 4,
    parameter int CHW   = 2,
    parameter int CW    = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           sync,
    input  logic           wr,
    input  logic [CHW-1:0] wr_ch,
    input  logic [CW-1:0]  wr_div,
    input  logic           wr_oneshot,
    input  logic [NCH-1:0] stop,
    output logic           ce_base,
    output logic [NCH-1:0] ce,
    output logic [NCH-1:0] active
);
    localparam int PDIV = TBASE / TCLK;
    logic [PSW-1:0] ps;
    logic [CW-1:0]  div [NCH];
    logic [CW-1:0]  cnt [NCH];
    logic [NCH-1:0] oneshot, run, fire;
    logic           tick;
    // sync suppresses the tick so no channel advances in the realign cycle
    assign tick    = en & ~sync & (ps == PSW'(PDIV - 1));
    assign ce_base = tick;
    assign active  = run;
    always_comb begin
        fire = '0;
        for (int i = 0; i < NCH; i++)
            fire[i] = tick & run[i] & (div[i] != '0) & (cnt[i] == div[i] - 1'b1);
    end
    always_ff @(posedge clk) begin
        if (rst || !en || sync)
            ps <= '0;
        else
            ps <= (ps == PSW'(PDIV - 1)) ? '0 : ps + 1'b1;
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (rst) begin
                div[i]     <= '0;
                cnt[i]     <= '0;
                oneshot[i] <= 1'b0;
                run[i]     <= 1'b0;
                ce[i]      <= 1'b0;
            end else begin
                ce[i] <= 1'b0;
                if (wr && wr_ch == CHW'(i)) begin
                    div[i]     <= wr_div;
                    oneshot[i] <= wr_oneshot;
                    cnt[i]     <= '0;
                    run[i]     <= 1'b1;
                end else if (stop[i]) begin
                    run[i] <= 1'b0;
                    cnt[i] <= '0;
                end else if (sync) begin
                    cnt[i] <= '0;
                end else if (tick && run[i] && div[i] != '0) begin
                    ce[i]  <= fire[i];
                    cnt[i] <= fire[i] ? '0 : cnt[i] + 1'b1;
                    if (fire[i] && oneshot[i])
                        run[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_gen_ce_multi.sv
// tb_gen_ce_multi: directed checks of prescaler, periodic/one-shot channels, stop, sync, wr and reset
module tb_gen_ce_multi;
    logic       clk = 1'b0;
    logic       rst, en, sync, wr, wr_oneshot;
    logic [1:0] wr_ch;
    logic [7:0] wr_div;
    logic [3:0] stop;
    logic       ce_base;
    logic [3:0] ce, active;
    int         tests = 0;
    int         fails = 0;

    gen_ce_multi #(.TCLK(20), .TBASE(100), .PSW(4), .NCH(4), .CHW(2), .CW(8)) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .wr(wr), .wr_ch(wr_ch),
        .wr_div(wr_div), .wr_oneshot(wr_oneshot), .stop(stop),
        .ce_base(ce_base), .ce(ce), .active(active)
    );

    always #5 clk = ~clk;

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr = 1'b0; sync = 1'b0; stop = '0; wr_ch = '0; wr_div = '0; wr_oneshot = 1'b0;
    endtask

    task automatic do_rst();
        idle();
        rst = 1'b1; en = 1'b0;
        next();
        rst = 1'b0; en = 1'b1;
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [7:0] d, input logic os);
        wr = 1'b1; wr_ch = ch; wr_div = d; wr_oneshot = os;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; idle();
        next(); next();
        rst = 1'b0;
        #1;
        tests++;
        if ({ce_base, active, ce} !== 9'b0) begin
            fails++;
            $display("FAIL reset_state got=%b exp=%b", {ce_base, active, ce}, 9'b0);
        end
        next();
        for (int c = 0; c < 20; c++) begin
            en = 1'b1;
            #2;
            tests++;
            if ({ce_base, active, ce} !== {(c % 5 == 4), 8'b0}) begin
                fails++;
                $display("FAIL prescaler c=%0d got=%b exp=%b", c, {ce_base, active, ce}, {(c % 5 == 4), 8'b0});
            end
            next();
        end
    endtask

    task automatic test_periodic();
        logic [3:0] ece, eact;
        do_rst();
        for (int c = 0; c < 62; c++) begin
            idle();
            if (c == 0) cfg(2'd0, 8'd3, 1'b0);
            ece  = (c > 0 && c % 15 == 0) ? 4'b0001 : 4'b0000;
            eact = (c >= 1) ? 4'b0001 : 4'b0000;
            #2;
            tests++;
            if ({active, ce} !== {eact, ece}) begin
                fails++;
                $display("FAIL periodic c=%0d got=%b exp=%b", c, {active, ce}, {eact, ece});
            end
            next();
        end
    endtask

    task automatic test_oneshot();
        logic [3:0] ece, eact;
        do_rst();
        for (int c = 0; c < 62; c++) begin
            idle();
            if (c == 0) cfg(2'd1, 8'd2, 1'b1);
            ece  = (c == 10) ? 4'b0010 : 4'b0000;
            eact = (c >= 1 && c < 10) ? 4'b0010 : 4'b0000;
            #2;
            tests++;
            if ({active, ce} !== {eact, ece}) begin
                fails++;
                $display("FAIL oneshot c=%0d got=%b exp=%b", c, {active, ce}, {eact, ece});
            end
            next();
        end
    endtask

    task automatic test_stop_div0();
        logic [3:0] ece, eact;
        do_rst();
        for (int c = 0; c < 40; c++) begin
            idle();
            if (c == 0) cfg(2'd2, 8'd1, 1'b0);
            if (c == 9) stop = 4'b0100;
            if (c == 12) cfg(2'd2, 8'd0, 1'b0);
            ece  = (c == 5) ? 4'b0100 : 4'b0000;
            eact = ((c >= 1 && c <= 9) || c >= 13) ? 4'b0100 : 4'b0000;
            #2;
            tests++;
            if ({active, ce} !== {eact, ece}) begin
                fails++;
                $display("FAIL stop_div0 c=%0d got=%b exp=%b", c, {active, ce}, {eact, ece});
            end
            next();
        end
    endtask

    task automatic test_sync();
        logic [3:0] ece;
        logic       both;
        do_rst();
        for (int c = 0; c < 100; c++) begin
            idle();
            if (c == 0) cfg(2'd0, 8'd4, 1'b0);
            if (c == 7) cfg(2'd3, 8'd4, 1'b0);
            if (c == 32) sync = 1'b1;
            both = (c >= 53 && (c - 53) % 20 == 0);
            ece  = (c <= 32) ? {c == 25, 2'b00, c == 20} : {both, 2'b00, both};
            #2;
            tests++;
            if (ce !== ece) begin
                fails++;
                $display("FAIL sync c=%0d got=%b exp=%b", c, ce, ece);
            end
            next();
        end
    endtask

    task automatic test_wr_fire_rst();
        logic [3:0] ece, eact;
        logic       ebase;
        do_rst();
        for (int c = 0; c < 42; c++) begin
            idle();
            rst = (c == 27);
            if (c == 0 || c == 9) cfg(2'd0, 8'd2, 1'b0);
            ece   = (c == 20) ? 4'b0001 : 4'b0000;
            eact  = (c >= 1 && c <= 27) ? 4'b0001 : 4'b0000;
            ebase = (c < 28) ? (c % 5 == 4) : ((c - 28) % 5 == 4);
            #2;
            tests++;
            if ({ebase, active, ce} !== {ebase, eact, ece} || ce_base !== ebase) begin
                fails++;
                $display("FAIL wr_fire_rst c=%0d got=%b exp=%b", c, {ce_base, active, ce}, {ebase, eact, ece});
            end
            next();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; idle();
        next();
        test_reset();
        test_periodic();
        test_oneshot();
        test_stop_div0();
        test_sync();
        test_wr_fire_rst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
